// File: rtl/polilock_nucleo.sv
// polilock_nucleo: parametrised lock core with multi-digit password, attempt limit,
// timed lockout and on-line password change.
module polilock_nucleo #(
  parameter int DIGITOS = 4,
  parameter int LARGURA_DIGITO = 4,
  parameter int MAX_TENTATIVAS = 3,
  parameter int T_BLOQUEIO = 100,
  parameter logic [DIGITOS*LARGURA_DIGITO-1:0] SENHA_INICIAL = 16'h1234
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      iniciar,
  input  logic [1:0]                funcao,
  input  logic [LARGURA_DIGITO-1:0] digito,
  input  logic                      digito_valido,
  output logic                      acertou,
  output logic                      errou,
  output logic                      gravou,
  output logic                      aberto,
  output logic                      bloqueado,
  output logic [3:0]                db_estado,
  output logic [3:0]                db_tentativas,
  output logic [3:0]                db_indice
);
  localparam int IW = DIGITOS > 1 ? $clog2(DIGITOS) : 1;
  localparam int TW = $clog2(MAX_TENTATIVAS + 1);
  localparam int CW = T_BLOQUEIO > 1 ? $clog2(T_BLOQUEIO) : 1;
  typedef enum logic [3:0] {
    OCIOSO = 4'd0, PREPARA = 4'd1, ENTRADA = 4'd2, AVALIA = 4'd3,
    ACERTO = 4'd4, ERRO = 4'd5, BLOQUEIO = 4'd6, GRAVA = 4'd7
  } estado_t;
  estado_t estado;
  logic [LARGURA_DIGITO-1:0] senha [DIGITOS];
  logic [LARGURA_DIGITO-1:0] sombra [DIGITOS];
  logic [IW-1:0] indice;
  logic [TW-1:0] tentativas, tent_inc;
  logic [CW-1:0] contador;
  logic modo, falha, ultimo;
  assign ultimo = indice == IW'(DIGITOS - 1);
  assign tent_inc = tentativas == TW'(MAX_TENTATIVAS) ? tentativas : tentativas + 1'b1;
  assign db_estado = estado;
  assign db_tentativas = 4'(tentativas);
  assign db_indice = 4'(indice);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      estado <= OCIOSO;
      for (int i = 0; i < DIGITOS; i++) begin
        senha[i] <= SENHA_INICIAL[(DIGITOS-1-i)*LARGURA_DIGITO +: LARGURA_DIGITO];
        sombra[i] <= '0;
      end
      indice <= '0;
      tentativas <= '0;
      contador <= '0;
      modo <= 1'b0;
      falha <= 1'b0;
      {acertou, errou, gravou, aberto, bloqueado} <= '0;
    end else begin
      {acertou, errou, gravou} <= '0;
      case (estado)
        OCIOSO: if (iniciar) begin
          if (funcao == 2'b00 || (funcao == 2'b01 && aberto)) begin
            modo <= funcao[0];
            estado <= PREPARA;
          end
          if (funcao == 2'b10) aberto <= 1'b0;
        end
        PREPARA: begin
          indice <= '0;
          falha <= 1'b0;
          estado <= ENTRADA;
        end
        // every digit is consumed; a mismatch only sets the sticky flag
        ENTRADA: if (digito_valido) begin
          if (modo) sombra[indice] <= digito;
          else if (digito != senha[indice]) falha <= 1'b1;
          indice <= ultimo ? '0 : indice + 1'b1;
          if (ultimo) estado <= modo ? GRAVA : AVALIA;
        end
        AVALIA: estado <= falha ? ERRO : ACERTO;
        ACERTO: begin
          acertou <= 1'b1;
          aberto <= 1'b1;
          tentativas <= '0;
          estado <= OCIOSO;
        end
        ERRO: begin
          errou <= 1'b1;
          tentativas <= tent_inc;
          if (tent_inc == TW'(MAX_TENTATIVAS)) begin
            bloqueado <= 1'b1;
            contador <= CW'(T_BLOQUEIO - 1);
            estado <= BLOQUEIO;
          end else estado <= OCIOSO;
        end
        BLOQUEIO: if (contador == '0) begin
          bloqueado <= 1'b0;
          tentativas <= '0;
          estado <= OCIOSO;
        end else contador <= contador - 1'b1;
        GRAVA: begin
          senha <= sombra;
          gravou <= 1'b1;
          estado <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
endmodule

// File: tb/tb_polilock_nucleo.sv
// tb_polilock_nucleo: directed bench; expected outputs are laid out on a per-cycle
// timeline derived from the lock's timing rules and compared every cycle.
module tb_polilock_nucleo;
  localparam int MAX = 3, T = 10, N = 400;
  logic clock = 0, reset = 0, iniciar = 0, digito_valido = 0;
  logic [1:0] funcao = 0;
  logic [3:0] digito = 0;
  logic acertou, errou, gravou, aberto, bloqueado;
  logic [3:0] db_estado, db_tentativas, db_indice;
  int e = 0, total = 0, bad = 0, lock_end = 0, m_tent = 0, n_bl = 0;
  bit m_ab = 0, ativo = 0;
  logic [15:0] m_senha = 16'h1234;
  int x_ac[N], x_er[N], x_gr[N], x_ab[N], x_bl[N], x_est[N], x_tent[N], x_idx[N];

  polilock_nucleo #(.DIGITOS(4), .LARGURA_DIGITO(4), .MAX_TENTATIVAS(MAX), .T_BLOQUEIO(T),
    .SENHA_INICIAL(16'h1234)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .funcao(funcao), .digito(digito),
    .digito_valido(digito_valido), .acertou(acertou), .errou(errou), .gravou(gravou),
    .aberto(aberto), .bloqueado(bloqueado), .db_estado(db_estado),
    .db_tentativas(db_tentativas), .db_indice(db_indice));

  always #5 clock = ~clock;
  always @(posedge clock) e <= e + 1;
  always @(negedge clock) if (bloqueado) n_bl++;

  task automatic chk(input string n, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", n, got, exp, e);
    end
  endtask

  always @(negedge clock) if (ativo && e < N) begin
    chk("acertou", int'(acertou), x_ac[e]);
    chk("errou", int'(errou), x_er[e]);
    chk("gravou", int'(gravou), x_gr[e]);
    chk("aberto", int'(aberto), x_ab[e]);
    chk("bloqueado", int'(bloqueado), x_bl[e]);
    chk("db_estado", int'(db_estado), x_est[e]);
    chk("db_tentativas", int'(db_tentativas), x_tent[e]);
    chk("db_indice", int'(db_indice), x_idx[e]);
  end

  // level s takes value v from cycle c onwards
  task automatic nivel(input int s, input int c, input int v);
    for (int i = c; i < N; i++)
      case (s)
        0: x_ab[i] = v;
        1: x_bl[i] = v;
        2: x_est[i] = v;
        3: x_tent[i] = v;
        default: x_idx[i] = v;
      endcase
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic verificar(input logic [15:0] w, input int gap);
    int k, n;
    int ed[4];
    bit ok;
    k = e + 1;
    for (int i = 0; i < 4; i++) ed[i] = k + 2 + i + (i >= 2 ? gap : 0);
    n = ed[3];
    if (k > lock_end) begin
      ok = w == m_senha;
      nivel(2, k, 1);
      nivel(2, k + 1, 2);
      for (int i = 0; i < 4; i++) nivel(4, ed[i], i == 3 ? 0 : i + 1);
      nivel(2, n, 3);
      nivel(2, n + 1, ok ? 4 : 5);
      nivel(2, n + 2, 0);
      if (ok) begin
        x_ac[n + 2] = 1;
        m_ab = 1;
        nivel(0, n + 2, 1);
        m_tent = 0;
        nivel(3, n + 2, 0);
      end else begin
        x_er[n + 2] = 1;
        m_tent++;
        nivel(3, n + 2, m_tent);
        if (m_tent == MAX) begin
          lock_end = n + 2 + T;
          m_tent = 0;
          nivel(2, n + 2, 6);
          nivel(1, n + 2, 1);
          nivel(2, lock_end, 0);
          nivel(1, lock_end, 0);
          nivel(3, lock_end, 0);
        end
      end
    end
    iniciar = 1;
    funcao = 2'b00;
    tick();
    iniciar = 0;
    for (int i = 0; i < 4; i++) begin
      while (e < ed[i] - 1) tick();
      digito = w[15 - 4*i -: 4];
      digito_valido = 1;
      tick();
      digito_valido = 0;
    end
    while (e < n + 3) tick();
  endtask

  task automatic alterar(input logic [15:0] w, input int nd);
    int k;
    k = e + 1;
    if (m_ab) begin
      nivel(2, k, 1);
      nivel(2, k + 1, 2);
      for (int i = 0; i < nd; i++) nivel(4, k + 2 + i, i == 3 ? 0 : i + 1);
      if (nd == 4) begin
        nivel(2, k + 5, 7);
        x_gr[k + 6] = 1;
        nivel(2, k + 6, 0);
        m_senha = w;
      end
    end
    iniciar = 1;
    funcao = 2'b01;
    tick();
    iniciar = 0;
    tick();
    for (int i = 0; i < nd; i++) begin
      digito = w[15 - 4*i -: 4];
      digito_valido = 1;
      tick();
    end
    digito_valido = 0;
    if (nd == 4) repeat (3) tick();
  endtask

  task automatic comando(input logic [1:0] f);
    if (f == 2'b10) begin
      nivel(0, e + 1, 0);
      m_ab = 0;
    end
    iniciar = 1;
    funcao = f;
    tick();
    iniciar = 0;
    tick();
  endtask

  task automatic pulso_reset();
    for (int s = 0; s < 5; s++) nivel(s, e, 0);
    for (int i = e; i < N; i++) begin
      x_ac[i] = 0;
      x_er[i] = 0;
      x_gr[i] = 0;
    end
    m_senha = 16'h1234;
    m_ab = 0;
    m_tent = 0;
    lock_end = 0;
    iniciar = 0;
    digito_valido = 0;
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: run did not finish, edge %0d", e);
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    reset = 1;
    ativo = 1;
    tick();
    chk("lit_reset_estado", int'(db_estado), 0);
    chk("lit_reset_aberto", int'(aberto), 0);
    verificar(16'h1234, 0);
    chk("lit_ok_aberto", int'(aberto), 1);
    chk("lit_ok_tent", int'(db_tentativas), 0);
    verificar(16'h9234, 0);
    chk("lit_err_tent", int'(db_tentativas), 1);
    chk("lit_err_aberto", int'(aberto), 1);
    verificar(16'h1235, 2);
    chk("lit_err2_tent", int'(db_tentativas), 2);
    verificar(16'h0000, 1);
    chk("lit_bloq", int'(bloqueado), 1);
    verificar(16'h1234, 0);
    while (e <= lock_end) tick();
    chk("lit_bloq_len", n_bl, 10);
    chk("lit_bloq_fim", int'(bloqueado), 0);
    chk("lit_bloq_tent", int'(db_tentativas), 0);
    verificar(16'h1234, 0);
    chk("lit_pos_bloq", int'(aberto), 1);
    alterar(16'h5678, 4);
    verificar(16'h1234, 0);
    chk("lit_antiga_tent", int'(db_tentativas), 1);
    verificar(16'h5678, 0);
    chk("lit_nova_tent", int'(db_tentativas), 0);
    comando(2'b10);
    chk("lit_trava", int'(aberto), 0);
    comando(2'b11);
    alterar(16'h9999, 4);
    chk("lit_alt_fechado", int'(db_estado), 0);
    verificar(16'h5678, 0);
    alterar(16'h1111, 2);
    pulso_reset();
    chk("lit_reset_meio", int'({acertou, errou, gravou, aberto, bloqueado}), 0);
    verificar(16'h1234, 0);
    chk("lit_final", int'(aberto), 1);
    ativo = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
